// File: rtl/drive_sequencer_pkg.sv
// Shared codes for the line-following car drive controller: tracker codes,
// sequencer states, H-bridge direction encodings and PWM mode codes.
package drive_sequencer_pkg;

    localparam logic [2:0] TRK_LEFT     = 3'd0;
    localparam logic [2:0] TRK_RIGHT    = 3'd1;
    localparam logic [2:0] TRK_STRAIGHT = 3'd2;
    localparam logic [2:0] TRK_SHARP_L  = 3'd3;
    localparam logic [2:0] TRK_SHARP_R  = 3'd4;
    localparam logic [2:0] TRK_LOST     = 3'd5;

    typedef enum logic [2:0] {
        ST_FOLLOW  = 3'd0,
        ST_BLOCKED = 3'd1,
        ST_REVERSE = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;
    localparam logic [1:0] DIR_BRK = 2'b11;

    localparam logic [2:0] PWM_STRAIGHT = 3'd2;
    localparam logic [2:0] PWM_SPIN_L   = 3'd3;
    localparam logic [2:0] PWM_SPIN_R   = 3'd4;
    localparam logic [2:0] PWM_REVERSE  = 3'd5;

    // Unused tracker codes 6 and 7 behave as straight.
    function automatic logic [2:0] norm_track(input logic [2:0] code);
        return (code > TRK_LOST) ? TRK_STRAIGHT : code;
    endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// Sensor inputs and motor-stage outputs of the drive sequencer.
interface drive_sequencer_if;
    logic       start;
    logic [2:0] track_state;
    logic       obstacle;
    logic       stop_en;
    logic [1:0] left_dir;
    logic [1:0] right_dir;
    logic [2:0] pwm_mode;
    logic [2:0] fsm_state;

    modport master (
        output start, track_state, obstacle, stop_en,
        input  left_dir, right_dir, pwm_mode, fsm_state
    );

    modport slave (
        input  start, track_state, obstacle, stop_en,
        output left_dir, right_dir, pwm_mode, fsm_state
    );
endinterface

// File: rtl/drive_sequencer_obstacle_filter.sv
// Level filter for the ultrasonic stop flag: a new level must persist for
// OBST_FILTER consecutive cycles before obst_q follows it.
module obstacle_filter #(
    parameter int OBST_FILTER = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic obst_raw,
    output logic obst_q
);

    localparam int CW = $clog2(OBST_FILTER + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            obst_q <= 1'b0;
        end else if (obst_raw == obst_q) begin
            cnt <= '0;
        end else if (cnt == CW'(OBST_FILTER - 1)) begin
            cnt    <= '0;
            obst_q <= ~obst_q;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// Drive controller: arbitrates line following, obstacle braking, timed reverse,
// lost-line search and halt, and registers the H-bridge / PWM / display codes.
//
// state    | meaning
// FOLLOW   | steer from tracker code
// BLOCKED  | braked on obstacle, waiting for it to clear or time out
// REVERSE  | timed reverse after a long block
// SEARCH   | spin toward the side the line was last seen on
// HALT     | braked, waiting for start
module drive_sequencer
    import drive_sequencer_pkg::*;
#(
    parameter int OBST_FILTER    = 100000,
    parameter int BLOCK_CYC      = 100000000,
    parameter int REVERSE_CYC    = 30000000,
    parameter int SEARCH_TIMEOUT = 200000000,
    parameter int CNT_W          = 28
) (
    input logic              clk,
    input logic              rst,
    drive_sequencer_if.slave bus
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   phase_cnt;
    logic               last_side, last_side_next;
    logic               obst_q;
    logic [2:0]         trk;
    logic               lost;
    logic               block_done, reverse_done, search_done;
    logic [1:0]         left_q, right_q, left_d, right_d;
    logic [2:0]         pwm_q, pwm_d;

    // Dropping stop_en resets the filter so the flag clears immediately.
    obstacle_filter #(.OBST_FILTER(OBST_FILTER)) u_obst_filter (
        .clk      (clk),
        .rst      (rst | ~bus.stop_en),
        .obst_raw (bus.obstacle & bus.stop_en),
        .obst_q   (obst_q)
    );

    assign trk          = norm_track(bus.track_state);
    assign lost         = (trk == TRK_LOST);
    assign block_done   = (phase_cnt == CNT_W'(BLOCK_CYC - 1));
    assign reverse_done = (phase_cnt == CNT_W'(REVERSE_CYC - 1));
    assign search_done  = (phase_cnt == CNT_W'(SEARCH_TIMEOUT - 1));

    always_comb begin
        state_next     = state;
        last_side_next = last_side;
        left_d         = DIR_BRK;
        right_d        = DIR_BRK;
        pwm_d          = PWM_STRAIGHT;

        case (state)
            ST_FOLLOW: begin
                if (trk == TRK_LEFT || trk == TRK_SHARP_L)
                    last_side_next = 1'b0;
                else if (trk == TRK_RIGHT || trk == TRK_SHARP_R)
                    last_side_next = 1'b1;
                if (obst_q)    state_next = ST_BLOCKED;
                else if (lost) state_next = ST_SEARCH;
            end
            ST_BLOCKED: begin
                if (!obst_q)         state_next = ST_FOLLOW;
                else if (block_done) state_next = ST_REVERSE;
            end
            ST_REVERSE: begin
                if (reverse_done) state_next = lost ? ST_SEARCH : ST_FOLLOW;
            end
            ST_SEARCH: begin
                if (obst_q)           state_next = ST_BLOCKED;
                else if (!lost)       state_next = ST_FOLLOW;
                else if (search_done) state_next = ST_HALT;
            end
            default: begin
                if (bus.start) state_next = ST_FOLLOW;
            end
        endcase

        // Outputs are computed for the state being entered and registered with it.
        case (state_next)
            ST_FOLLOW: begin
                case (trk)
                    TRK_LEFT, TRK_RIGHT, TRK_STRAIGHT: begin
                        left_d  = DIR_FWD;
                        right_d = DIR_FWD;
                        pwm_d   = trk;
                    end
                    TRK_SHARP_L: begin
                        left_d  = DIR_REV;
                        right_d = DIR_FWD;
                        pwm_d   = PWM_SPIN_L;
                    end
                    TRK_SHARP_R: begin
                        left_d  = DIR_FWD;
                        right_d = DIR_REV;
                        pwm_d   = PWM_SPIN_R;
                    end
                    default: begin
                        left_d  = DIR_FWD;
                        right_d = DIR_FWD;
                        pwm_d   = PWM_STRAIGHT;
                    end
                endcase
            end
            ST_REVERSE: begin
                left_d  = DIR_REV;
                right_d = DIR_REV;
                pwm_d   = PWM_REVERSE;
            end
            ST_SEARCH: begin
                left_d  = last_side ? DIR_FWD : DIR_REV;
                right_d = last_side ? DIR_REV : DIR_FWD;
                pwm_d   = last_side ? PWM_SPIN_R : PWM_SPIN_L;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HALT;
            phase_cnt <= '0;
            last_side <= 1'b0;
            left_q    <= DIR_BRK;
            right_q   <= DIR_BRK;
            pwm_q     <= PWM_STRAIGHT;
        end else begin
            state     <= state_next;
            last_side <= last_side_next;
            left_q    <= left_d;
            right_q   <= right_d;
            pwm_q     <= pwm_d;
            if (state_next != state)
                phase_cnt <= '0;
            else if (state == ST_BLOCKED || state == ST_REVERSE || state == ST_SEARCH)
                phase_cnt <= phase_cnt + CNT_W'(1);
        end
    end

    assign bus.left_dir  = left_q;
    assign bus.right_dir = right_q;
    assign bus.pwm_mode  = pwm_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with shortened timing parameters.
module tb_drive_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;

    drive_sequencer_if bus();

    drive_sequencer #(
        .OBST_FILTER(4), .BLOCK_CYC(20), .REVERSE_CYC(10),
        .SEARCH_TIMEOUT(30), .CNT_W(28)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {fsm_state, left_dir, right_dir, pwm_mode}
    function automatic logic [9:0] obs();
        return {bus.fsm_state, bus.left_dir, bus.right_dir, bus.pwm_mode};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.track_state = 3'd2;
        bus.obstacle = 1'b0; bus.stop_en = 1'b1;
        step(2);
        tests_run++;
        if (obs() !== {3'd4, 2'b11, 2'b11, 3'd2}) begin
            $display("FAIL reset_state got %b expected %b", obs(), {3'd4, 2'b11, 2'b11, 3'd2});
            tests_failed++;
        end
        rst = 1'b0;
        step(2);
        tests_run++;
        if (obs() !== {3'd4, 2'b11, 2'b11, 3'd2}) begin
            $display("FAIL halt_idle got %b expected %b", obs(), {3'd4, 2'b11, 2'b11, 3'd2});
            tests_failed++;
        end
    endtask

    task automatic test_follow();
        logic [2:0] codes [5] = '{3'd2, 3'd3, 3'd0, 3'd7, 3'd4};
        logic [9:0] exp   [5] = '{{3'd0, 2'b10, 2'b10, 3'd2}, {3'd0, 2'b01, 2'b10, 3'd3},
                                  {3'd0, 2'b10, 2'b10, 3'd0}, {3'd0, 2'b10, 2'b10, 3'd2},
                                  {3'd0, 2'b10, 2'b01, 3'd4}};
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.track_state = codes[i];
            step(1);
            bus.start = 1'b0;
            tests_run++;
            if (obs() !== exp[i]) begin
                $display("FAIL follow_code%0d got %b expected %b", codes[i], obs(), exp[i]);
                tests_failed++;
            end
        end
        bus.track_state = 3'd2; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd2}) begin
            $display("FAIL start_ignored got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd2});
            tests_failed++;
        end
    endtask

    task automatic test_obstacle_filter();
        bus.obstacle = 1'b1;
        step(3);
        bus.obstacle = 1'b0;
        step(2);
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd2}) begin
            $display("FAIL short_glitch got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd2});
            tests_failed++;
        end
        bus.obstacle = 1'b1;
        step(4);
        tests_run++;
        if (bus.fsm_state !== 3'd0) begin
            $display("FAIL filter_edge4 got %0d expected 0", bus.fsm_state);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (obs() !== {3'd1, 2'b11, 2'b11, 3'd2}) begin
            $display("FAIL blocked_entry got %b expected %b", obs(), {3'd1, 2'b11, 2'b11, 3'd2});
            tests_failed++;
        end
        bus.obstacle = 1'b0;
        step(4);
        tests_run++;
        if (bus.fsm_state !== 3'd1) begin
            $display("FAIL blocked_hold got %0d expected 1", bus.fsm_state);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd2}) begin
            $display("FAIL unblock got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd2});
            tests_failed++;
        end
    endtask

    task automatic test_block_reverse();
        bus.obstacle = 1'b1;
        step(5);
        step(19);
        tests_run++;
        if (bus.fsm_state !== 3'd1) begin
            $display("FAIL block_last_cycle got %0d expected 1", bus.fsm_state);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (obs() !== {3'd2, 2'b01, 2'b01, 3'd5}) begin
            $display("FAIL reverse_entry got %b expected %b", obs(), {3'd2, 2'b01, 2'b01, 3'd5});
            tests_failed++;
        end
        step(5);
        bus.obstacle = 1'b0;
        step(4);
        tests_run++;
        if (obs() !== {3'd2, 2'b01, 2'b01, 3'd5}) begin
            $display("FAIL reverse_last_cycle got %b expected %b", obs(), {3'd2, 2'b01, 2'b01, 3'd5});
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd2}) begin
            $display("FAIL reverse_exit got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd2});
            tests_failed++;
        end
    endtask

    task automatic test_search();
        bus.track_state = 3'd4;
        step(1);
        bus.track_state = 3'd5;
        step(1);
        tests_run++;
        if (obs() !== {3'd3, 2'b10, 2'b01, 3'd4}) begin
            $display("FAIL search_right got %b expected %b", obs(), {3'd3, 2'b10, 2'b01, 3'd4});
            tests_failed++;
        end
        step(6);
        bus.track_state = 3'd1;
        step(1);
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd1}) begin
            $display("FAIL search_found got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd1});
            tests_failed++;
        end
        // Line reappears exactly as the timeout fires: FOLLOW must win.
        bus.track_state = 3'd5;
        step(1);
        step(29);
        bus.track_state = 3'd2;
        step(1);
        tests_run++;
        if (bus.fsm_state !== 3'd0) begin
            $display("FAIL found_vs_timeout got %0d expected 0", bus.fsm_state);
            tests_failed++;
        end
        bus.track_state = 3'd5;
        step(1);
        step(29);
        tests_run++;
        if (bus.fsm_state !== 3'd3) begin
            $display("FAIL search_last_cycle got %0d expected 3", bus.fsm_state);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (obs() !== {3'd4, 2'b11, 2'b11, 3'd2}) begin
            $display("FAIL search_timeout got %b expected %b", obs(), {3'd4, 2'b11, 2'b11, 3'd2});
            tests_failed++;
        end
    endtask

    task automatic test_stop_en();
        bus.track_state = 3'd2; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.stop_en = 1'b0; bus.obstacle = 1'b1;
        step(50);
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd2}) begin
            $display("FAIL stop_disabled got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd2});
            tests_failed++;
        end
        bus.obstacle = 1'b0; bus.stop_en = 1'b1;
        bus.track_state = 3'd3;
        step(1);
        bus.track_state = 3'd5;
        step(1);
        tests_run++;
        if (obs() !== {3'd3, 2'b01, 2'b10, 3'd3}) begin
            $display("FAIL search_left got %b expected %b", obs(), {3'd3, 2'b01, 2'b10, 3'd3});
            tests_failed++;
        end
        bus.obstacle = 1'b1;
        step(4);
        bus.track_state = 3'd2;
        step(1);
        tests_run++;
        if (obs() !== {3'd1, 2'b11, 2'b11, 3'd2}) begin
            $display("FAIL obst_vs_found got %b expected %b", obs(), {3'd1, 2'b11, 2'b11, 3'd2});
            tests_failed++;
        end
        bus.stop_en = 1'b0;
        step(1);
        tests_run++;
        if (bus.fsm_state !== 3'd1) begin
            $display("FAIL stop_en_drop_lag got %0d expected 1", bus.fsm_state);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd2}) begin
            $display("FAIL stop_en_drop got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd2});
            tests_failed++;
        end
        bus.obstacle = 1'b0; bus.stop_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bus.obstacle = 1'b1;
        step(25);
        bus.obstacle = 1'b0;
        tests_run++;
        if (bus.fsm_state !== 3'd2) begin
            $display("FAIL reach_reverse got %0d expected 2", bus.fsm_state);
            tests_failed++;
        end
        step(3);
        rst = 1'b1; bus.start = 1'b1;
        step(1);
        rst = 1'b0; bus.start = 1'b0;
        tests_run++;
        if (obs() !== {3'd4, 2'b11, 2'b11, 3'd2}) begin
            $display("FAIL reset_mid got %b expected %b", obs(), {3'd4, 2'b11, 2'b11, 3'd2});
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (bus.fsm_state !== 3'd4) begin
            $display("FAIL reset_beats_start got %0d expected 4", bus.fsm_state);
            tests_failed++;
        end
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        tests_run++;
        if (obs() !== {3'd0, 2'b10, 2'b10, 3'd2}) begin
            $display("FAIL restart got %b expected %b", obs(), {3'd0, 2'b10, 2'b10, 3'd2});
            tests_failed++;
        end
        bus.obstacle = 1'b1;
        step(24);
        tests_run++;
        if (bus.fsm_state !== 3'd1) begin
            $display("FAIL fresh_block_len got %0d expected 1", bus.fsm_state);
            tests_failed++;
        end
        step(1);
        tests_run++;
        if (bus.fsm_state !== 3'd2) begin
            $display("FAIL fresh_block_end got %0d expected 2", bus.fsm_state);
            tests_failed++;
        end
        bus.obstacle = 1'b0;
    endtask

    initial begin
        test_reset();
        test_follow();
        test_obstacle_filter();
        test_block_reverse();
        test_search();
        test_stop_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
